// File: rtl/wb_pkg.sv
// Shared types for the register-file write-back slice: data/address widths
// and the load-return entry carried through the load FIFO.
package wb_pkg;
  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  // Source chosen for the write port in a given cycle
  typedef enum logic [1:0] {
    SEL_IDLE   = 2'd0,
    SEL_ALU    = 2'd1,
    SEL_FIFO   = 2'd2,
    SEL_BYPASS = 2'd3
  } wb_sel_e;
endpackage

// File: rtl/wb_writeback_unit_if.sv
// Bundle of the execute/memory-side handshakes, the decode scoreboard query
// and the register-file write port of the write-back unit.
// master: pipeline side driving results/queries; slave: the write-back unit.
interface wb_writeback_unit_if;
  import wb_pkg::*;

  logic              alu_valid;
  logic [REG_AW-1:0] alu_rd;
  logic [XLEN-1:0]   alu_data;
  logic              ld_valid;
  logic              ld_ready;
  logic [REG_AW-1:0] ld_rd;
  logic [XLEN-1:0]   ld_data;
  logic              iss_valid;
  logic [REG_AW-1:0] iss_rd;
  logic [REG_AW-1:0] q_rs1;
  logic [REG_AW-1:0] q_rs2;
  logic              q_busy1;
  logic              q_busy2;
  logic [REG_AW-1:0] wr_addr;
  logic [XLEN-1:0]   wr_data;
  logic              write_en;
  logic [1:0]        err;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data,
    input  ld_ready,
    output iss_valid, iss_rd, q_rs1, q_rs2,
    input  q_busy1, q_busy2,
    input  wr_addr, wr_data, write_en, err
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data,
    output ld_ready,
    input  iss_valid, iss_rd, q_rs1, q_rs2,
    output q_busy1, q_busy2,
    output wr_addr, wr_data, write_en, err
  );
endinterface

// File: rtl/wb_ld_fifo.sv
// Load-return FIFO: DEPTH entries of wb_entry_t, strict first-in first-out.
// Push and pop may happen in the same cycle; storage is not reset, only the
// pointers and occupancy count are.
module wb_ld_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  wb_entry_t              push_data,
  input  logic                   pop,
  output wb_entry_t              head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Entry storage, written on accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/wb_writeback_unit.sv
// Write-side master for the 32x32 register file. Merges ALU results and
// buffered load returns onto one registered write port, and keeps the
// pending-load scoreboard that decode queries.
// Optional feature macro: WB_LD_BYPASS_EN lets a load skip the empty FIFO
// when no ALU result competes, giving 1-cycle load latency.
module wb_writeback_unit
  import wb_pkg::*;
#(
  parameter int LD_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  wb_writeback_unit_if.slave  bus
);
  localparam int CW = $clog2(LD_DEPTH) + 1;

  wb_entry_t           fifo_head;
  wb_entry_t           ld_entry_p0;
  logic [CW-1:0]       fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_push;
  logic                fifo_pop;

  logic                ld_acc_p0;
  logic                alu_sel_p0;
  wb_sel_e             sel_p0;
  logic [REG_AW-1:0]   win_rd_p0;
  logic [XLEN-1:0]     win_data_p0;
  logic                win_ld_p0;
  logic [NUM_REGS-1:0] pend_nxt_p0;
  logic [1:0]          err_set_p0;

  logic [REG_AW-1:0]   wr_addr_p1;
  logic [XLEN-1:0]     wr_data_p1;
  logic                vld_p1;
  logic [NUM_REGS-1:0] pend_p1;
  logic [1:0]          err_p1;

  // ---- stage p0: arbitration between ALU, FIFO head and (optionally) bypass
  assign bus.ld_ready = ~fifo_full;
  assign ld_acc_p0    = bus.ld_valid & ~fifo_full;
  assign alu_sel_p0   = bus.alu_valid & (bus.alu_rd != '0);
  assign ld_entry_p0  = '{rd: bus.ld_rd, data: bus.ld_data};

  // Priority select: ALU, then oldest buffered load, then idle or bypass
  always_comb begin
    sel_p0 = SEL_IDLE;
    if (alu_sel_p0)       sel_p0 = SEL_ALU;
    else if (!fifo_empty) sel_p0 = SEL_FIFO;
`ifdef WB_LD_BYPASS_EN
    else if (ld_acc_p0)   sel_p0 = SEL_BYPASS;
`endif
  end

  assign fifo_pop  = (sel_p0 == SEL_FIFO);
  assign fifo_push = ld_acc_p0 & (sel_p0 != SEL_BYPASS);

  wb_ld_fifo #(
    .DEPTH (LD_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (ld_entry_p0),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Winner mux feeding the write-port register
  always_comb begin
    win_rd_p0   = '0;
    win_data_p0 = '0;
    win_ld_p0   = 1'b0;
    case (sel_p0)
      SEL_ALU: begin
        win_rd_p0   = bus.alu_rd;
        win_data_p0 = bus.alu_data;
      end
      SEL_FIFO: begin
        win_rd_p0   = fifo_head.rd;
        win_data_p0 = fifo_head.data;
        win_ld_p0   = 1'b1;
      end
      SEL_BYPASS: begin
        win_rd_p0   = bus.ld_rd;
        win_data_p0 = bus.ld_data;
        win_ld_p0   = 1'b1;
      end
      default: ;
    endcase
  end

  // Scoreboard update: a load write clears its register, a new issue sets it (set wins)
  always_comb begin
    pend_nxt_p0 = pend_p1;
    if (win_ld_p0 && (win_rd_p0 != '0)) pend_nxt_p0[win_rd_p0] = 1'b0;
    if (bus.iss_valid && (bus.iss_rd != '0)) pend_nxt_p0[bus.iss_rd] = 1'b1;
    pend_nxt_p0[0] = 1'b0;
  end

  assign err_set_p0[0] = bus.iss_valid & pend_p1[bus.iss_rd];
  assign err_set_p0[1] = (sel_p0 == SEL_ALU) & pend_p1[bus.alu_rd];

  // ---- stage p1: registered write port, scoreboard and sticky error flags
  // Write port register; x0 destinations never raise write_en
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      wr_addr_p1 <= win_rd_p0;
      wr_data_p1 <= win_data_p0;
      vld_p1     <= (sel_p0 != SEL_IDLE) & (win_rd_p0 != '0);
    end
  end

  // Pending-load bits and sticky hazard flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_p1 <= '0;
      err_p1  <= '0;
    end else begin
      pend_p1 <= pend_nxt_p0;
      err_p1  <= err_p1 | err_set_p0;
    end
  end

  assign bus.wr_addr  = wr_addr_p1;
  assign bus.wr_data  = wr_data_p1;
  assign bus.write_en = vld_p1;
  assign bus.err      = err_p1;
  assign bus.q_busy1  = pend_p1[bus.q_rs1];
  assign bus.q_busy2  = pend_p1[bus.q_rs2];
endmodule

// File: tb/tb_wb_writeback_unit.sv
// Bench for wb_writeback_unit: directed scenarios followed by random traffic,
// all checked against a queue-based reference model of the write-back rules.
module tb_wb_writeback_unit;
  import wb_pkg::*;

  localparam int LD_DEPTH = 4;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  wb_writeback_unit_if bus ();

  wb_writeback_unit #(
    .LD_DEPTH (LD_DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  wb_entry_t   m_q[$];
  bit [31:0]   m_pend;
  bit [1:0]    m_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit av, input int ard, input logic [31:0] ad,
                       input bit lv, input int lrd, input logic [31:0] ld,
                       input bit iv, input int ird, input int q1, input int q2);
    bus.alu_valid = av;
    bus.alu_rd    = 5'(ard);
    bus.alu_data  = ad;
    bus.ld_valid  = lv;
    bus.ld_rd     = 5'(lrd);
    bus.ld_data   = ld;
    bus.iss_valid = iv;
    bus.iss_rd    = 5'(ird);
    bus.q_rs1     = 5'(q1);
    bus.q_rs2     = 5'(q2);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // One clock of traffic: check combinational outputs, advance the model,
  // cross the edge, then check the registered write port and error flags.
  task automatic step();
    bit        acc;
    bit        e_we;
    bit [4:0]  e_addr;
    bit [31:0] e_data;
    bit [31:0] nxt_pend;
    wb_entry_t ent;
    #1;
    check("ld_ready", bus.ld_ready, (m_q.size() < LD_DEPTH));
    check("q_busy1", bus.q_busy1, m_pend[bus.q_rs1]);
    check("q_busy2", bus.q_busy2, m_pend[bus.q_rs2]);

    acc      = bus.ld_valid && (m_q.size() < LD_DEPTH);
    e_we     = 0;
    e_addr   = 0;
    e_data   = 0;
    nxt_pend = m_pend;
    if (bus.iss_valid && m_pend[bus.iss_rd]) m_err[0] = 1;
    if (bus.alu_valid && bus.alu_rd != 0) begin
      e_we = 1; e_addr = bus.alu_rd; e_data = bus.alu_data;
      if (m_pend[bus.alu_rd]) m_err[1] = 1;
    end else if (m_q.size() > 0) begin
      ent = m_q.pop_front();
      if (ent.rd != 0) begin
        e_we = 1; e_addr = ent.rd; e_data = ent.data;
        nxt_pend[ent.rd] = 0;
      end
    end
`ifdef WB_LD_BYPASS_EN
    else if (acc) begin
      acc = 0;
      if (bus.ld_rd != 0) begin
        e_we = 1; e_addr = bus.ld_rd; e_data = bus.ld_data;
        nxt_pend[bus.ld_rd] = 0;
      end
    end
`endif
    if (acc) m_q.push_back('{rd: bus.ld_rd, data: bus.ld_data});
    if (bus.iss_valid && bus.iss_rd != 0) nxt_pend[bus.iss_rd] = 1;
    m_pend = nxt_pend;

    @(posedge clk);
    #1;
    check("write_en", bus.write_en, e_we);
    if (e_we) begin
      check("wr_addr", bus.wr_addr, e_addr);
      check("wr_data", bus.wr_data, e_data);
    end
    check("err", bus.err, m_err);
  endtask

  // Asynchronous reset in the middle of a cycle; model is flushed with it.
  task automatic apply_reset();
    @(negedge clk);
    idle();
    reset = 1'b1;
    #1;
    m_q.delete();
    m_pend = 0;
    m_err  = 0;
    check("rst_write_en", bus.write_en, 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_wr_data", bus.wr_data, 0);
    check("rst_err", bus.err, 0);
    @(posedge clk);
    #1;
    check("rst_write_en_hold", bus.write_en, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_ld_ready", bus.ld_ready, 1);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    m_pend = 0;
    m_err  = 0;
    repeat (2) @(posedge clk);
    apply_reset();

    // 1: ALU write lands next cycle
    drive(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0);
    step();
    check("t1_we", bus.write_en, 1);
    check("t1_addr", bus.wr_addr, 5);
    check("t1_data", bus.wr_data, 32'hDEAD_BEEF);

    // 2: ALU and load in the same cycle; load follows one cycle later
    drive(0, 0, 0, 0, 0, 0, 1, 4, 4, 0);
    step();
    drive(1, 3, 32'h0000_0333, 1, 4, 32'h0000_0444, 0, 0, 4, 0);
    step();
    check("t2_alu_addr", bus.wr_addr, 3);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 4, 0);
    step();
    check("t2_ld_we", bus.write_en, 1);
    check("t2_ld_addr", bus.wr_addr, 4);
    check("t2_ld_data", bus.wr_data, 32'h0000_0444);
    #1;
    check("t2_pend_clear", bus.q_busy1, 0);

    // 3: fill the FIFO behind continuous ALU traffic, then drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1, 1 + i, 32'h100 + i, 1, 20 + i, 32'hA000 + i, 0, 0, 0, 0);
      step();
    end
    check("t3_full", bus.ld_ready, 0);
    drive(1, 6, 32'h600, 1, 24, 32'hBAD, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      idle();
      step();
      check("t3_order", bus.wr_addr, 20 + i);
      check("t3_data", bus.wr_data, 32'hA000 + i);
    end
    idle();
    step();
    check("t3_no_extra", bus.write_en, 0);

    // 4: x0 destinations never write
    drive(1, 0, 32'h1234, 1, 0, 32'h5678, 1, 0, 0, 0);
    step();
    check("t4_we0", bus.write_en, 0);
    idle();
    step();
    check("t4_we1", bus.write_en, 0);
    #1;
    check("t4_ready", bus.ld_ready, 1);

    // 5: scoreboard and hazard flags
    drive(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    #1;
    check("t5_busy", bus.q_busy1, 1);
    step();
    check("t5_err0", bus.err, 2'b01);
    drive(1, 7, 32'h77, 0, 0, 0, 0, 0, 7, 0);
    step();
    check("t5_err1", bus.err, 2'b11);

`ifdef WB_LD_BYPASS_EN
    idle();
    step();
    drive(0, 0, 0, 1, 9, 32'h9999, 0, 0, 0, 0);
    step();
    check("byp_we", bus.write_en, 1);
    check("byp_addr", bus.wr_addr, 9);
`endif

    // 6: reset with buffered loads discards them
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 32'h11, 1, 10 + i, 32'hC000 + i, 1, 10 + i, 0, 0);
      step();
    end
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 10 + i, 12);
      step();
      check("t6_no_write", bus.write_en, 0);
    end

    // Random traffic with small register range to provoke hazards
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 99) < 45), $urandom_range(0, 7), $urandom(),
            ($urandom_range(0, 99) < 55), $urandom_range(0, 7), $urandom(),
            ($urandom_range(0, 99) < 20), $urandom_range(0, 7),
            $urandom_range(0, 31), $urandom_range(0, 31));
      step();
      if (i == 200) apply_reset();
    end
    idle();
    for (int i = 0; i < 6; i++) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
